// File: rtl/ldtu_gainsel_cfg_ctrl.sv
// Purpose : sequences GAIN_SEL_MODE / shift_gain_10 / SATURATION_value changes into the gain-selection datapath.
// Latency : APPLY follows QUIET_LEN consecutive baseline cycles (or TIMEOUT waiting cycles); cfg_ack comes L+1 cycles after APPLY.
// Backpr. : level request / one-cycle ack handshake; cfg_req is ignored while busy and in the ack cycle.
//
// Ports:
//   CLK, reset (async, active-low)
//   cfg_req, cfg_mode_in, cfg_shift_in, cfg_sat_in : request from the register bank
//   baseline_flag                                  : voted baseline flag from the input FIFO
//   cfg_ack, cfg_busy, blank, timeout_flag         : handshake / status / encoder gate
//   GAIN_SEL_MODE, shift_gain_10, SATURATION_value : registered configuration to the datapath
module ldtu_gainsel_cfg_ctrl #(
   parameter int unsigned QUIET_LEN  = 4,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned SETTLE_W8  = 12,
   parameter int unsigned SETTLE_W16 = 20,
   parameter int unsigned CNT_W      = 8
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        cfg_req,
   input  logic [1:0]  cfg_mode_in,
   input  logic [1:0]  cfg_shift_in,
   input  logic [11:0] cfg_sat_in,
   input  logic        baseline_flag,
   output logic        cfg_ack,
   output logic        cfg_busy,
   output logic        blank,
   output logic        timeout_flag,
   output logic [1:0]  GAIN_SEL_MODE,
   output logic [1:0]  shift_gain_10,
   output logic [11:0] SATURATION_value
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_QUIET = 2'd1,
      APPLY      = 2'd2,
      SETTLE     = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_LEN - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TO_MAX     = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] W8_LAST    = CNT_W'(SETTLE_W8 - 1);
   localparam logic [CNT_W-1:0] W16_LAST   = CNT_W'(SETTLE_W16 - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] quiet_cnt_q, quiet_cnt_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
   logic             settle_long_q, settle_long_d;
   logic             ack_en_q, ack_en_d;
   logic             cfg_ack_q, cfg_ack_d;
   logic             timeout_q, timeout_d;
   logic [1:0]       mode_q, mode_d;
   logic [1:0]       shift_q, shift_d;
   logic [11:0]      sat_q, sat_d;
   logic [1:0]       sh_mode_q, sh_mode_d;
   logic [1:0]       sh_shift_q, sh_shift_d;
   logic [11:0]      sh_sat_q, sh_sat_d;

   logic             accept, cfg_same, quiet_hit, to_hit, enter_apply, settle_done;
   logic [CNT_W-1:0] settle_last;

   // A request is only taken in IDLE and never in the ack cycle, so a requester
   // that holds cfg_req for one cycle after ack is not served twice.
   assign accept      = (state_q == IDLE) && cfg_req && !cfg_ack_q;
   assign cfg_same    = ({cfg_mode_in, cfg_shift_in, cfg_sat_in} == {mode_q, shift_q, sat_q});
   assign quiet_hit   = baseline_flag && (quiet_cnt_q == QUIET_LAST);
   assign to_hit      = (to_cnt_q == TO_LAST);
   assign enter_apply = (state_q == WAIT_QUIET) && (quiet_hit || to_hit);
   assign settle_last = settle_long_q ? W16_LAST : W8_LAST;
   assign settle_done = (state_q == SETTLE) && (settle_cnt_q == settle_last);

   // state register
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) state_q <= SETTLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (accept && !cfg_same) state_d = WAIT_QUIET;
         WAIT_QUIET: if (quiet_hit || to_hit) state_d = APPLY;
         APPLY:      state_d = SETTLE;
         SETTLE:     if (settle_done) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // counters, shadow and configuration registers
   always_comb begin
      sh_mode_d     = sh_mode_q;
      sh_shift_d    = sh_shift_q;
      sh_sat_d      = sh_sat_q;
      quiet_cnt_d   = quiet_cnt_q;
      to_cnt_d      = to_cnt_q;
      settle_cnt_d  = settle_cnt_q;
      settle_long_d = settle_long_q;
      ack_en_d      = ack_en_q;
      timeout_d     = timeout_q;
      mode_d        = mode_q;
      shift_d       = shift_q;
      sat_d         = sat_q;
      cfg_ack_d     = 1'b0;

      if (accept) begin
         sh_mode_d   = cfg_mode_in;
         sh_shift_d  = cfg_shift_in;
         sh_sat_d    = cfg_sat_in;
         quiet_cnt_d = '0;
         to_cnt_d    = '0;
         timeout_d   = 1'b0;
         cfg_ack_d   = cfg_same;   // no-op request: ack without disturbing the datapath
      end

      if (state_q == WAIT_QUIET) begin
         to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + CNT_W'(1);
         if (!baseline_flag)        quiet_cnt_d = '0;
         else if (quiet_cnt_q != '1) quiet_cnt_d = quiet_cnt_q + CNT_W'(1);
      end

      // All three fields load on one edge so the datapath never sees a mixed config.
      if (enter_apply) begin
         mode_d  = sh_mode_q;
         shift_d = sh_shift_q;
         sat_d   = sh_sat_q;
         if (!quiet_hit) timeout_d = 1'b1;   // quiet wins a tie with the timeout
      end

      if (state_q == APPLY) begin
         settle_cnt_d  = '0;
         settle_long_d = (mode_q == 2'b01);  // 16-sample window needs the longer refill
         ack_en_d      = 1'b1;
      end

      if (state_q == SETTLE) begin
         if (settle_done) begin
            cfg_ack_d = ack_en_q;             // the post-reset settle has ack_en_q == 0
            ack_en_d  = 1'b0;
         end else begin
            settle_cnt_d = settle_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         quiet_cnt_q   <= '0;
         to_cnt_q      <= '0;
         settle_cnt_q  <= '0;
         settle_long_q <= 1'b0;
         ack_en_q      <= 1'b0;
         cfg_ack_q     <= 1'b0;
         timeout_q     <= 1'b0;
         mode_q        <= 2'b00;
         shift_q       <= 2'b00;
         sat_q         <= 12'hfff;
         sh_mode_q     <= 2'b00;
         sh_shift_q    <= 2'b00;
         sh_sat_q      <= 12'h000;
      end else begin
         quiet_cnt_q   <= quiet_cnt_d;
         to_cnt_q      <= to_cnt_d;
         settle_cnt_q  <= settle_cnt_d;
         settle_long_q <= settle_long_d;
         ack_en_q      <= ack_en_d;
         cfg_ack_q     <= cfg_ack_d;
         timeout_q     <= timeout_d;
         mode_q        <= mode_d;
         shift_q       <= shift_d;
         sat_q         <= sat_d;
         sh_mode_q     <= sh_mode_d;
         sh_shift_q    <= sh_shift_d;
         sh_sat_q      <= sh_sat_d;
      end
   end

   // outputs
   always_comb begin
      cfg_busy         = (state_q != IDLE);
      blank            = (state_q == APPLY) || (state_q == SETTLE);
      cfg_ack          = cfg_ack_q;
      timeout_flag     = timeout_q;
      GAIN_SEL_MODE    = mode_q;
      shift_gain_10    = shift_q;
      SATURATION_value = sat_q;
   end

endmodule
